// File: rtl/dafx_axi_slave.sv
// AXI4-Lite register file for the DAFX audio subsystem: RW config registers,
// RO status/version, and one-cycle command pulses for the write-only clear registers.
`timescale 1ns/1ps
module dafx_axi_slave #(
  parameter int                          AXI_ADDR_WIDTH_P = 16,
  parameter int                          AXI_DATA_WIDTH_P = 64,
  parameter logic [AXI_DATA_WIDTH_P-1:0] HW_VERSION_P     = 64'h0000_0000_0001_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ADDR_WIDTH_P-1:0]   awaddr_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,
  input  logic [AXI_DATA_WIDTH_P-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH_P/8-1:0] wstrb_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic [1:0]                    bresp_o,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  input  logic [AXI_ADDR_WIDTH_P-1:0]   araddr_i,
  input  logic                          arvalid_i,
  output logic                          arready_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_mix_out_gain_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_mix_ch_gain_0_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_mix_ch_gain_1_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_mix_ch_gain_2_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_mix_ch_gain_3_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_osc0_waveform_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_osc0_frequency_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_osc0_duty_cycle_o,
  output logic [AXI_DATA_WIDTH_P-1:0]   cr_cpu_led_o,
  input  logic [AXI_DATA_WIDTH_P-1:0]   sr_cir_min_adc_i,
  input  logic [AXI_DATA_WIDTH_P-1:0]   sr_cir_max_adc_i,
  input  logic [AXI_DATA_WIDTH_P-1:0]   sr_cir_min_dac_i,
  input  logic [AXI_DATA_WIDTH_P-1:0]   sr_cir_max_dac_i,
  input  logic [AXI_DATA_WIDTH_P-1:0]   sr_mix_out_left_i,
  input  logic [AXI_DATA_WIDTH_P-1:0]   sr_mix_out_right_i,
  output logic                          cmd_clear_adc_amplitude_o,
  output logic                          cmd_clear_irq_0_o,
  output logic                          cmd_clear_irq_1_o
);

  localparam int STRB_W = AXI_DATA_WIDTH_P / 8;
  localparam int NUM_CR = 9;

  // Word index = byte address [15:3]; 8-byte stride, low bits ignored.
  localparam logic [12:0] IDX_VERSION   = 13'd0;
  localparam logic [12:0] IDX_CR_FIRST  = 13'd1;
  localparam logic [12:0] IDX_CR_LAST   = 13'd9;
  localparam logic [12:0] IDX_MIN_ADC   = 13'd10;
  localparam logic [12:0] IDX_MAX_ADC   = 13'd11;
  localparam logic [12:0] IDX_MIN_DAC   = 13'd12;
  localparam logic [12:0] IDX_MAX_DAC   = 13'd13;
  localparam logic [12:0] IDX_CLR_ADC   = 13'd14;
  localparam logic [12:0] IDX_CLR_IRQ0  = 13'd15;
  localparam logic [12:0] IDX_CLR_IRQ1  = 13'd16;
  localparam logic [12:0] IDX_MIX_LEFT  = 13'd17;
  localparam logic [12:0] IDX_MIX_RIGHT = 13'd18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  wstate_e                       wstate_q, wstate_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic [12:0]                   aw_idx_q, aw_idx_d;
  logic [AXI_DATA_WIDTH_P-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [2:0]                    cmd_q, cmd_d;
  logic [AXI_DATA_WIDTH_P-1:0]   cr_q [NUM_CR];
  logic [AXI_DATA_WIDTH_P-1:0]   cr_d [NUM_CR];

  rstate_e                       rstate_q, rstate_d;
  logic                          rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH_P-1:0]   rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic [12:0]                   ar_idx;
  logic [AXI_DATA_WIDTH_P-1:0]   rd_data;
  logic [1:0]                    rd_resp;
  logic                          wr_is_rw, wr_is_cmd;
  logic [3:0]                    wr_cr_sel;

  assign wr_is_rw  = (aw_idx_q >= IDX_CR_FIRST) && (aw_idx_q <= IDX_CR_LAST);
  assign wr_is_cmd = (aw_idx_q == IDX_CLR_ADC) || (aw_idx_q == IDX_CLR_IRQ0) ||
                     (aw_idx_q == IDX_CLR_IRQ1);
  assign wr_cr_sel = aw_idx_q[3:0] - 4'd1;

  // Each channel stays closed from its capture until the write response completes.
  assign awready_o = !aw_done_q;
  assign wready_o  = !w_done_q;

  // ---------------- write path ----------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    wstate_d  = wstate_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    cmd_d     = '0;
    cr_d      = cr_q;

    unique case (wstate_q)
      W_IDLE: begin
        if (awvalid_i && !aw_done_q) begin
          aw_done_d = 1'b1;
          aw_idx_d  = awaddr_i[15:3];
        end
        if (wvalid_i && !w_done_q) begin
          w_done_d = 1'b1;
          wdata_d  = wdata_i;
          wstrb_d  = wstrb_i;
        end
        if (aw_done_q && w_done_q) begin
          if (wr_is_rw) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wstrb_q[b]) cr_d[wr_cr_sel][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
          end
          cmd_d[0] = (aw_idx_q == IDX_CLR_ADC);
          cmd_d[1] = (aw_idx_q == IDX_CLR_IRQ0);
          cmd_d[2] = (aw_idx_q == IDX_CLR_IRQ1);
          bresp_d  = (wr_is_rw || wr_is_cmd) ? RESP_OKAY : RESP_SLVERR;
          bvalid_d = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          bvalid_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      cmd_q     <= '0;
      // NOTE: the register array is reset word by word; these are config flops, not RAM.
      for (int i = 0; i < NUM_CR; i++) cr_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      cmd_q     <= cmd_d;
      cr_q      <= cr_d;
    end
  end

  // ---------------- read path ----------------
  assign ar_idx    = araddr_i[15:3];
  assign arready_o = (rstate_q == R_IDLE);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if ((ar_idx >= IDX_CR_FIRST) && (ar_idx <= IDX_CR_LAST)) begin
      rd_data = cr_q[ar_idx[3:0] - 4'd1];
    end else begin
      unique case (ar_idx)
        IDX_VERSION:   rd_data = HW_VERSION_P;
        IDX_MIN_ADC:   rd_data = sr_cir_min_adc_i;
        IDX_MAX_ADC:   rd_data = sr_cir_max_adc_i;
        IDX_MIN_DAC:   rd_data = sr_cir_min_dac_i;
        IDX_MAX_DAC:   rd_data = sr_cir_max_dac_i;
        IDX_MIX_LEFT:  rd_data = sr_mix_out_left_i;
        IDX_MIX_RIGHT: rd_data = sr_mix_out_right_i;
        IDX_CLR_ADC, IDX_CLR_IRQ0, IDX_CLR_IRQ1: rd_data = '0;
        default:       rd_resp = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (arvalid_i) begin
          rdata_d  = rd_data;
          rresp_d  = rd_resp;
          rvalid_d = 1'b1;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready_i) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

  assign cr_mix_out_gain_o    = cr_q[0];
  assign cr_mix_ch_gain_0_o   = cr_q[1];
  assign cr_mix_ch_gain_1_o   = cr_q[2];
  assign cr_mix_ch_gain_2_o   = cr_q[3];
  assign cr_mix_ch_gain_3_o   = cr_q[4];
  assign cr_osc0_waveform_o   = cr_q[5];
  assign cr_osc0_frequency_o  = cr_q[6];
  assign cr_osc0_duty_cycle_o = cr_q[7];
  assign cr_cpu_led_o         = cr_q[8];

  assign cmd_clear_adc_amplitude_o = cmd_q[0];
  assign cmd_clear_irq_0_o         = cmd_q[1];
  assign cmd_clear_irq_1_o         = cmd_q[2];

endmodule

// File: tb/tb_dafx_axi_slave.sv
// Directed self-checking bench for dafx_axi_slave; drives inputs after the falling
// edge and samples outputs at the falling edge, away from the active rising edge.
`timescale 1ns/1ps
module tb_dafx_axi_slave;

  localparam logic [63:0] VERSION = 64'h0000_0000_0001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [63:0] cr_out_gain, cr_ch0, cr_ch1, cr_ch2, cr_ch3, cr_wave, cr_freq, cr_duty, cr_led;
  logic [63:0] sr_min_adc, sr_max_adc, sr_min_dac, sr_max_dac, sr_left, sr_right;
  logic        cmd_adc, cmd_irq0, cmd_irq1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] cmd_at_b, cmd_after_b;

  always #5 clk = ~clk;

  dafx_axi_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .cr_mix_out_gain_o(cr_out_gain), .cr_mix_ch_gain_0_o(cr_ch0), .cr_mix_ch_gain_1_o(cr_ch1),
    .cr_mix_ch_gain_2_o(cr_ch2), .cr_mix_ch_gain_3_o(cr_ch3), .cr_osc0_waveform_o(cr_wave),
    .cr_osc0_frequency_o(cr_freq), .cr_osc0_duty_cycle_o(cr_duty), .cr_cpu_led_o(cr_led),
    .sr_cir_min_adc_i(sr_min_adc), .sr_cir_max_adc_i(sr_max_adc),
    .sr_cir_min_dac_i(sr_min_dac), .sr_cir_max_dac_i(sr_max_dac),
    .sr_mix_out_left_i(sr_left), .sr_mix_out_right_i(sr_right),
    .cmd_clear_adc_amplitude_o(cmd_adc), .cmd_clear_irq_0_o(cmd_irq0), .cmd_clear_irq_1_o(cmd_irq1)
  );

  wire [575:0] cr_flat = {cr_out_gain, cr_ch0, cr_ch1, cr_ch2, cr_ch3, cr_wave, cr_freq, cr_duty, cr_led};
  wire [2:0]   cmd_vec = {cmd_irq1, cmd_irq0, cmd_adc};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // aw_lag delays AW relative to W; hold_b leaves the response un-acknowledged.
  task automatic axi_write(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int aw_lag, input bit hold_b, output logic [1:0] resp);
    bit aw_sent = 1'b0;
    bit w_sent  = 1'b0;
    bit aw_hs, w_hs;
    int cyc = 0;
    resp   = 2'bxx;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_sent && w_sent) && cyc < 40) begin
      @(negedge clk);
      awvalid = !aw_sent && (cyc >= aw_lag);
      wvalid  = !w_sent;
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      @(posedge clk);
      if (aw_hs) aw_sent = 1'b1;
      if (w_hs)  w_sent  = 1'b1;
      cyc++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (!(aw_sent && w_sent)) begin
      check("write_accept_timeout", 0, 1);
      return;
    end
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bvalid) begin
      check("bvalid_timeout", 0, 1);
      return;
    end
    resp     = bresp;
    cmd_at_b = cmd_vec;
    if (hold_b) return;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready      = 1'b0;
    cmd_after_b = cmd_vec;
    check("bvalid_single", bvalid, 0);
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [63:0] data,
                          output logic [1:0] resp, output int lat);
    bit hs = 1'b0;
    int cyc = 0;
    araddr = addr;
    while (!hs && cyc < 20) begin
      @(negedge clk);
      arvalid = 1'b1;
      hs      = arready;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  logic [63:0] rd, snap_rdata;
  logic [1:0]  rs, ws;
  int          lat;
  logic [575:0] snap_cr;
  logic [15:0] ro_addr [6];
  logic [63:0] ro_val  [6];
  logic [15:0] cmd_addr [3];
  logic [2:0]  cmd_exp  [3];

  initial begin
    rst_n = 1'b0;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    sr_min_adc = 64'h1234;               sr_max_adc = 64'hA5A5_0000_0000_0001;
    sr_min_dac = 64'h0000_FFFF_0000_0002; sr_max_dac = 64'h7FFF_FFFF_FFFF_FFFF;
    sr_left    = 64'hDEAD_BEEF_0000_0011; sr_right   = 64'h8000_0000_0000_0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_handshake", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    check("rst_cmd", cmd_vec, 0);
    check("rst_cr_any", |cr_flat, 0);

    axi_read(16'h0000, rd, rs, lat);
    check("ver_data", rd, VERSION);
    check("ver_resp", rs, 2'b00);
    check("ver_latency", lat, 1);
    for (int a = 8; a <= 16'h48; a += 8) begin
      axi_read(16'(a), rd, rs, lat);
      check($sformatf("cr_reset_rd_%0h", a), {rd[61:0], rs}, 0);
    end

    axi_write(16'h0038, 64'h1122_3344_5566_7788, 8'h0F, 3, 1'b0, ws);
    check("freq_bresp", ws, 2'b00);
    check("freq_cr", cr_freq, 64'h0000_0000_5566_7788);
    axi_read(16'h0038, rd, rs, lat);
    check("freq_rd", rd, 64'h0000_0000_5566_7788);
    axi_write(16'h003F, 64'hAABB_CCDD_EEFF_0011, 8'hF0, 0, 1'b0, ws);
    check("freq_merge_cr", cr_freq, 64'hAABB_CCDD_5566_7788);
    axi_write(16'h0048, 64'h0000_0000_0000_00C3, 8'h01, 0, 1'b0, ws);
    check("led_cr", cr_led, 64'hC3);
    axi_read(16'h004D, rd, rs, lat);
    check("led_rd_lowbits", rd, 64'hC3);

    cmd_addr[0] = 16'h0070; cmd_exp[0] = 3'b001;
    cmd_addr[1] = 16'h0078; cmd_exp[1] = 3'b010;
    cmd_addr[2] = 16'h0080; cmd_exp[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      snap_cr = cr_flat;
      axi_write(cmd_addr[i], 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0, ws);
      check($sformatf("cmd_resp_%0h", cmd_addr[i]), ws, 2'b00);
      check($sformatf("cmd_pulse_%0h", cmd_addr[i]), cmd_at_b, cmd_exp[i]);
      check($sformatf("cmd_clear_%0h", cmd_addr[i]), cmd_after_b, 0);
      check($sformatf("cmd_no_cr_%0h", cmd_addr[i]), cr_flat == snap_cr, 1);
      axi_read(cmd_addr[i], rd, rs, lat);
      check($sformatf("cmd_rd_%0h", cmd_addr[i]), {rd[61:0], rs}, 0);
    end

    snap_cr = cr_flat;
    axi_write(16'h0050, 64'h5555, 8'hFF, 0, 1'b0, ws);
    check("ro_wr_slverr", ws, 2'b10);
    axi_write(16'h00A0, 64'h6666, 8'hFF, 2, 1'b0, ws);
    check("unmap_wr_slverr", ws, 2'b10);
    axi_write(16'h0000, 64'h7777, 8'hFF, 0, 1'b0, ws);
    check("ver_wr_slverr", ws, 2'b10);
    check("slverr_no_cr", cr_flat == snap_cr, 1);
    axi_read(16'h00A0, rd, rs, lat);
    check("unmap_rd_data", rd, 0);
    check("unmap_rd_resp", rs, 2'b10);
    axi_read(16'h0098, rd, rs, lat);
    check("unmap_edge_resp", rs, 2'b10);
    axi_read(16'h0000, rd, rs, lat);
    check("ver_after_wr", rd, VERSION);

    ro_addr[0] = 16'h0050; ro_val[0] = 64'h1234;
    ro_addr[1] = 16'h0058; ro_val[1] = 64'hA5A5_0000_0000_0001;
    ro_addr[2] = 16'h0060; ro_val[2] = 64'h0000_FFFF_0000_0002;
    ro_addr[3] = 16'h0068; ro_val[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    ro_addr[4] = 16'h0088; ro_val[4] = 64'hDEAD_BEEF_0000_0011;
    ro_addr[5] = 16'h0090; ro_val[5] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      axi_read(ro_addr[i], rd, rs, lat);
      check($sformatf("ro_rd_%0h", ro_addr[i]), rd, ro_val[i]);
      check($sformatf("ro_resp_%0h", ro_addr[i]), rs, 2'b00);
    end

    // Concurrent write and read of 0x10 with both responses stalled.
    @(negedge clk);
    awaddr = 16'h0010; wdata = 64'h0102_0304_0506_0708; wstrb = 8'hFF;
    araddr = 16'h0010;
    {awvalid, wvalid, arvalid} = 3'b111;
    @(posedge clk);
    @(negedge clk);
    {awvalid, wvalid, arvalid} = 3'b000;
    @(negedge clk);
    snap_rdata = rdata;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_flags_%0d", i), {bvalid, rvalid, awready, wready, arready}, 5'b11000);
      check($sformatf("hold_rdata_%0d", i), rdata, 64'h0);
      check($sformatf("hold_stable_%0d", i), rdata === snap_rdata, 1);
      @(negedge clk);
    end
    check("hold_bresp", bresp, 2'b00);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("hold_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    check("ch0_cr", cr_ch0, 64'h0102_0304_0506_0708);
    axi_read(16'h0010, rd, rs, lat);
    check("ch0_rd", rd, 64'h0102_0304_0506_0708);

    // Reset while a write response is pending.
    axi_write(16'h0008, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 1'b1, ws);
    check("pre_rst_bvalid", bvalid, 1);
    check("pre_rst_gain", cr_out_gain, 64'hCAFE_F00D_1234_5678);
    rst_n = 1'b0;
    #1;
    check("rst_mid_bvalid", bvalid, 0);
    check("rst_mid_gain", cr_out_gain, 0);
    check("rst_mid_cr_any", |cr_flat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
